// File: rtl/ball_box_overlay.sv
// rtl/ball_box_overlay.sv - draws a square outline around the latest ball position on RGB565 video
// Optional build macro BALL_CROSSHAIR_EN adds a centre cross inside the box.
module ball_box_overlay #(
  parameter int          IMG_W       = 640,
  parameter int          IMG_H       = 480,
  parameter int          BOX_HALF    = 16,
  parameter logic [15:0] BOX_COLOR   = 16'hF800,
  parameter int          HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x_coor,
  input  logic [9:0]  y_coor,
  input  logic        coor_valid_flag,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        de_i,
  input  logic [15:0] rgb_i,
  output logic        vsync_o,
  output logic        hsync_o,
  output logic        de_o,
  output logic [15:0] rgb_o,
  output logic        target_locked
);

  localparam logic [9:0]        W10    = 10'(IMG_W);
  localparam logic [9:0]        H10    = 10'(IMG_H);
  localparam logic signed [10:0] HALF_S = 11'(BOX_HALF);
  localparam logic signed [10:0] W_MAX  = 11'(IMG_W - 1);
  localparam logic signed [10:0] H_MAX  = 11'(IMG_H - 1);
  localparam logic [7:0]        HOLD8  = 8'(HOLD_FRAMES);

  logic        vsync_q, de_q;
  logic [9:0]  col, row;
  logic [9:0]  pend_x, pend_y;
  logic        pend_valid;
  logic [9:0]  act_x, act_y;
  logic        loaded;
  logic [7:0]  miss_cnt;
  logic        box_on;
  logic [9:0]  bnd_l, bnd_r, bnd_t, bnd_b;

  logic        frame_start, accept, promote;
  logic [9:0]  src_x, src_y;
  logic [7:0]  miss_next;
  logic signed [10:0] sx_s, sy_s, lo_x, hi_x, lo_y, hi_y;
  logic [9:0]  l_next, r_next, t_next, b_next;
  logic        in_box, mark, draw;

  always_comb begin
    frame_start = vsync_i & ~vsync_q;
    accept      = coor_valid_flag && (x_coor < W10) && (y_coor < H10);
    promote     = frame_start && (pend_valid || accept);
    // A strobe landing exactly on frame start bypasses the pending register.
    src_x       = accept ? x_coor : pend_x;
    src_y       = accept ? y_coor : pend_y;
    if (promote)
      miss_next = 8'd0;
    else if (miss_cnt == 8'hFF)
      miss_next = 8'hFF;
    else
      miss_next = miss_cnt + 8'd1;

    sx_s   = signed'({1'b0, src_x});
    sy_s   = signed'({1'b0, src_y});
    lo_x   = sx_s - HALF_S;
    hi_x   = sx_s + HALF_S;
    lo_y   = sy_s - HALF_S;
    hi_y   = sy_s + HALF_S;
    l_next = (lo_x < 11'sd0) ? 10'd0 : 10'(lo_x);
    r_next = (hi_x > W_MAX)  ? 10'(W_MAX) : 10'(hi_x);
    t_next = (lo_y < 11'sd0) ? 10'd0 : 10'(lo_y);
    b_next = (hi_y > H_MAX)  ? 10'(H_MAX) : 10'(hi_y);

    in_box = (row >= bnd_t) && (row <= bnd_b) && (col >= bnd_l) && (col <= bnd_r);
`ifdef BALL_CROSSHAIR_EN
    mark   = (col == bnd_l) || (col == bnd_r) || (row == bnd_t) || (row == bnd_b) ||
             (row == act_y) || (col == act_x);
`else
    mark   = (col == bnd_l) || (col == bnd_r) || (row == bnd_t) || (row == bnd_b);
`endif
    draw   = de_i && box_on && in_box && mark;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      de_q       <= 1'b0;
      col        <= '0;
      row        <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_valid <= 1'b0;
      act_x      <= '0;
      act_y      <= '0;
      loaded     <= 1'b0;
      miss_cnt   <= 8'hFF;
      box_on     <= 1'b0;
      bnd_l      <= '0;
      bnd_r      <= '0;
      bnd_t      <= '0;
      bnd_b      <= '0;
      vsync_o    <= 1'b0;
      hsync_o    <= 1'b0;
      de_o       <= 1'b0;
      rgb_o      <= 16'h0000;
    end else begin
      vsync_q <= vsync_i;
      de_q    <= de_i;
      col     <= de_i ? col + 10'd1 : 10'd0;
      if (frame_start)
        row <= '0;
      else if (de_q && !de_i && row != H10)
        row <= row + 10'd1;

      if (frame_start) begin
        pend_valid <= 1'b0;
        miss_cnt   <= miss_next;
        box_on     <= (loaded || promote) && (miss_next < HOLD8);
        if (promote) begin
          loaded <= 1'b1;
          act_x  <= src_x;
          act_y  <= src_y;
          bnd_l  <= l_next;
          bnd_r  <= r_next;
          bnd_t  <= t_next;
          bnd_b  <= b_next;
        end
      end else if (accept) begin
        pend_x     <= x_coor;
        pend_y     <= y_coor;
        pend_valid <= 1'b1;
      end

      vsync_o <= vsync_i;
      hsync_o <= hsync_i;
      de_o    <= de_i;
      rgb_o   <= draw ? BOX_COLOR : rgb_i;
    end
  end

  assign target_locked = box_on;

endmodule

// File: tb/tb_ball_box_overlay.sv
// tb/tb_ball_box_overlay.sv - randomized self-checking bench for ball_box_overlay (honours BALL_CROSSHAIR_EN)
module tb_ball_box_overlay;
  localparam int          W     = 40;
  localparam int          H     = 30;
  localparam int          HALF  = 5;
  localparam int          HOLD  = 3;
  localparam logic [15:0] COLOR = 16'hF800;
  localparam int          HBLANK = 6;
  localparam int          PRE    = 6;
  localparam int          POST   = 4;
  localparam int          LINE   = W + HBLANK;
  localparam int          FRAME  = PRE + H * LINE + POST;
`ifdef BALL_CROSSHAIR_EN
  localparam bit XH = 1'b1;
`else
  localparam bit XH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x_coor = '0, y_coor = '0;
  logic        coor_valid_flag = 1'b0;
  logic        vsync_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0;
  logic [15:0] rgb_i = '0;
  logic        vsync_o, hsync_o, de_o, target_locked;
  logic [15:0] rgb_o;

  ball_box_overlay #(.IMG_W(W), .IMG_H(H), .BOX_HALF(HALF), .BOX_COLOR(COLOR),
                     .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .x_coor(x_coor), .y_coor(y_coor),
    .coor_valid_flag(coor_valid_flag), .vsync_i(vsync_i), .hsync_i(hsync_i),
    .de_i(de_i), .rgb_i(rgb_i), .vsync_o(vsync_o), .hsync_o(hsync_o),
    .de_o(de_o), .rgb_o(rgb_o), .target_locked(target_locked));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: last accepted coordinate, frames since last update, box geometry.
  bit m_loaded, m_have_pend, m_box;
  int m_missing, m_px, m_py, m_ax, m_ay, m_l, m_r, m_t, m_b;

  logic [19:0] exp_out = '0;
  bit          chk_en = 1'b0;
  int          cur_tag = -1;

  typedef struct { int tag; int r; int c; bit drawn; } pin_t;
  pin_t pins[$];

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({vsync_o, hsync_o, de_o, target_locked, rgb_o} !== exp_out) begin
        errors++;
        $display("FAIL out t=%0t got vs/hs/de/lock/rgb=%b%b%b%b/%h required=%b%b%b%b/%h",
                 $time, vsync_o, hsync_o, de_o, target_locked, rgb_o,
                 exp_out[19], exp_out[18], exp_out[17], exp_out[16], exp_out[15:0]);
      end
    end
  end

  task automatic step(input bit vs, input bit hs, input bit de, input bit stb,
                      input int sx, input int sy, input bit fs, input int r,
                      input int c, input bit rst);
    logic [15:0] pix;
    logic [19:0] exp_n;
    bit acc, draw;
    do pix = 16'($urandom); while (pix == COLOR);
    vsync_i = vs; hsync_i = hs; de_i = de; rgb_i = pix;
    coor_valid_flag = stb; x_coor = 10'(sx); y_coor = 10'(sy);
    rst_n = !rst;
    draw = 1'b0;
    if (rst) begin
      m_loaded = 0; m_have_pend = 0; m_box = 0; m_missing = 255;
      exp_n = '0;
    end else begin
      acc = stb && sx < W && sy < H;
      if (fs) begin
        if (acc || m_have_pend) begin
          m_ax = acc ? sx : m_px;
          m_ay = acc ? sy : m_py;
          m_loaded = 1; m_missing = 0; m_have_pend = 0;
          m_l = (m_ax - HALF < 0) ? 0 : m_ax - HALF;
          m_r = (m_ax + HALF > W - 1) ? W - 1 : m_ax + HALF;
          m_t = (m_ay - HALF < 0) ? 0 : m_ay - HALF;
          m_b = (m_ay + HALF > H - 1) ? H - 1 : m_ay + HALF;
        end else if (m_missing < 255) begin
          m_missing++;
        end
        m_box = m_loaded && m_missing < HOLD;
      end else if (acc) begin
        m_px = sx; m_py = sy; m_have_pend = 1;
      end
      if (de && m_box && r >= m_t && r <= m_b && c >= m_l && c <= m_r)
        draw = (c == m_l || c == m_r || r == m_t || r == m_b ||
                (XH && (r == m_ay || c == m_ax)));
      exp_n = {vs, hs, de, m_box, draw ? COLOR : pix};
    end
    @(posedge clk);
    #1;
    exp_out = exp_n;
    chk_en  = 1'b1;
    if (!rst && de) begin
      foreach (pins[k]) begin
        if (pins[k].tag == cur_tag && pins[k].r == r && pins[k].c == c) begin
          checks++;
          if (rgb_o !== (pins[k].drawn ? COLOR : pix)) begin
            errors++;
            $display("FAIL pin tag%0d r%0d c%0d got=%h required=%h", cur_tag, r, c,
                     rgb_o, pins[k].drawn ? COLOR : pix);
          end
        end
      end
    end
  endtask

  // mode 0: no strobe, 1: random strobes, 2: strobe on frame-start cycle, 3: strobe mid-frame
  task automatic run_frame(input int tag, input int mode, input int fx, input int fy,
                           input int rst_line);
    int ns;
    int sc[3], sxv[3], syv[3];
    cur_tag = tag;
    ns = 0;
    if (mode == 1) begin
      ns = $urandom_range(0, 3);
      for (int j = 0; j < 3; j++) begin
        sc[j]  = $urandom_range(0, FRAME - 1);
        sxv[j] = $urandom_range(0, W + 10);
        syv[j] = $urandom_range(0, H + 8);
      end
    end else if (mode == 2 || mode == 3) begin
      ns = 1; sxv[0] = fx; syv[0] = fy;
      sc[0] = (mode == 2) ? 0 : $urandom_range(1, FRAME - 1);
    end
    for (int i = 0; i < FRAME; i++) begin
      bit vs, hs, de, stb, rst;
      int r, c, k, sx, sy;
      vs = (i < 2); hs = 0; de = 0; r = 0; c = 0; rst = 0;
      if (i >= PRE && i < PRE + H * LINE) begin
        k  = i - PRE;
        r  = k / LINE;
        c  = k % LINE;
        de = (c < W);
        hs = (c == W + 1 || c == W + 2);
        rst = (rst_line >= 0 && r == rst_line && c >= 10 && c < 14);
      end
      stb = 0; sx = 0; sy = 0;
      for (int j = 0; j < ns; j++)
        if (sc[j] == i) begin stb = 1; sx = sxv[j]; sy = syv[j]; end
      step(vs, hs, de, stb, sx, sy, i == 0, r, c, rst);
    end
  endtask

  task automatic check_lock(input int tag, input bit req);
    checks++;
    if (target_locked !== req) begin
      errors++;
      $display("FAIL lock tag%0d got=%b required=%b", tag, target_locked, req);
    end
  endtask

  task automatic add_pin(input int tag, input int r, input int c, input bit drawn);
    pin_t p;
    p.tag = tag; p.r = r; p.c = c; p.drawn = drawn;
    pins.push_back(p);
  endtask

  initial begin
    // box at (20,15): L15 R25 T10 B20
    add_pin(2, 10, 15, 1); add_pin(2, 10, 25, 1); add_pin(2, 20, 20, 1);
    add_pin(2, 14, 15, 1); add_pin(2, 14, 25, 1); add_pin(2, 14, 16, 0);
    add_pin(2, 9, 15, 0);  add_pin(2, 10, 26, 0); add_pin(2, 15, 20, XH);
    add_pin(2, 12, 20, XH); add_pin(2, 15, 16, XH);
    // clamped box at (2,28): L0 R7 T23 B29
    add_pin(3, 29, 0, 1); add_pin(3, 25, 0, 1); add_pin(3, 25, 7, 1);
    add_pin(3, 25, 39, 0); add_pin(3, 0, 3, 0); add_pin(3, 23, 3, 1);
    add_pin(3, 25, 3, 0);
    add_pin(5, 29, 0, 1); add_pin(5, 15, 20, 0);
    add_pin(6, 29, 0, 0);
    // box at (30,5): L25 R35 T0 B10
    add_pin(8, 0, 25, 1); add_pin(8, 0, 36, 0);

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_frame(0, 0, 0, 0, 3);      check_lock(0, 0);
    run_frame(1, 3, 20, 15, -1);   check_lock(1, 0);
    run_frame(2, 0, 0, 0, -1);     check_lock(2, 1);
    run_frame(3, 2, 2, 28, -1);    check_lock(3, 1);
    run_frame(4, 3, 700, 10, -1);  check_lock(4, 1);
    run_frame(5, 0, 0, 0, -1);     check_lock(5, 1);
    run_frame(6, 0, 0, 0, -1);     check_lock(6, 0);
    run_frame(7, 3, 30, 5, -1);    check_lock(7, 0);
    run_frame(8, 0, 0, 0, -1);     check_lock(8, 1);
    for (int t = 9; t < 21; t++) run_frame(t, 1, 0, 0, -1);
    run_frame(21, 0, 0, 0, 10);
    run_frame(22, 0, 0, 0, -1);    check_lock(22, 0);
    run_frame(23, 3, 12, 12, -1);
    run_frame(24, 0, 0, 0, -1);    check_lock(24, 1);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
